ulpi_reg_port: RTL and testbench

- Parametrised ULPI link-side register-access engine.
- Replaces hard-coded TXCMD sequencing (OTG Control and Function Control writes) with a queued, generic register port.
- Supports immediate and extended-address writes and reads, DIR abort/retry, NXT timeout and RXCMD capture.
- Sits between the top-level USB control FSM (reset, chirp and linestate logic) and the ULPI pad tristate in top.

---
 rtl/ulpi_reg_port.sv | 257 +++++++++++++++++++++++++
 tb/tb_ulpi_reg_port.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_reg_port.sv
// ---------------------------------------------------------------------------
// ulpi_reg_port
//
// ULPI link-side register access engine. Requests from the USB control FSM
// are queued in a small FIFO and executed one at a time as ULPI TXCMD
// register writes or reads. Extended addressing is supported. A PHY that
// grabs the bus (DIR) mid-transfer causes an abort and a retry. A transfer
// that waits on the PHY for too long ends with an error response. RXCMD
// bytes sent by the PHY while it owns the bus are captured at all times.
//
// Request handshake: a request is accepted on every rising CLK edge where
// REQ_VALID=1 and REQ_READY=1. REQ_WR, REQ_ADDR and REQ_WDATA are sampled
// on that edge. REQ_READY is registered and depends only on FIFO fill. It
// never depends on REQ_VALID. Responses have no back-pressure: RSP_VALID is
// a one-cycle pulse, and RSP_ERR and RSP_RDATA are meaningful in that cycle.
//
// Ports:
//   CLK, RST            60 MHz ULPI clock, synchronous active-high reset
//   REQ_VALID/READY     request handshake
//   REQ_WR/ADDR/WDATA   request payload (1 = write, 0 = read)
//   RSP_VALID/ERR       completion pulse and error qualifier
//   RSP_RDATA           last read data, held between reads
//   BUSY                FIFO non-empty or engine not idle
//   ULPI_DIR/NXT        PHY direction and throttle
//   ULPI_DATA_IN/OUT/OE pad data in, data out and drive enable
//   ULPI_STP            stop strobe to the PHY
//   RXCMD_VALID/RXCMD   captured RXCMD pulse and byte
//   LINESTATE           RXCMD[1:0] of the last captured RXCMD
// ---------------------------------------------------------------------------
module ulpi_reg_port #(
   parameter int REQ_DEPTH   = 4,
   parameter bit EXT_ADDR_EN = 1'b1,
   parameter bit READ_EN     = 1'b1,
   parameter int TIMEOUT     = 1023
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       REQ_VALID,
   output logic       REQ_READY,
   input  logic       REQ_WR,
   input  logic [7:0] REQ_ADDR,
   input  logic [7:0] REQ_WDATA,
   output logic       RSP_VALID,
   output logic [7:0] RSP_RDATA,
   output logic       RSP_ERR,
   output logic       BUSY,
   input  logic       ULPI_DIR,
   input  logic       ULPI_NXT,
   input  logic [7:0] ULPI_DATA_IN,
   output logic [7:0] ULPI_DATA_OUT,
   output logic       ULPI_DATA_OE,
   output logic       ULPI_STP,
   output logic       RXCMD_VALID,
   output logic [7:0] RXCMD,
   output logic [1:0] LINESTATE
);

   localparam int AW = $clog2(REQ_DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]   FULL_CNT  = REQ_DEPTH[AW:0];
   localparam logic [TW-1:0] TMO_LIMIT = TIMEOUT[TW-1:0];

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_EXT, S_WDATA, S_STOP, S_RTURN, S_RDATA, S_WAIT_TA
   } state_t;

   state_t          state;
   logic            dir_q;
   logic            head_started;   // current head has entered CMD at least once
   logic [TW-1:0]   tmo_cnt;

   // ---------------- request FIFO: entry = {wr, addr, wdata} ----------------
   logic [16:0]     fifo_mem [REQ_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     fifo_cnt, fifo_cnt_nxt;
   logic            push, pop, fifo_nempty;
   logic            head_wr;
   logic [7:0]      head_addr, head_wdata;

   assign push        = REQ_VALID & REQ_READY;
   assign fifo_nempty = (fifo_cnt != '0);
   assign head_wr     = fifo_mem[rd_ptr][16];
   assign head_addr   = fifo_mem[rd_ptr][15:8];
   assign head_wdata  = fifo_mem[rd_ptr][7:0];
   assign fifo_cnt_nxt = fifo_cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

   always_ff @(posedge CLK) begin
      if (push) fifo_mem[wr_ptr] <= {REQ_WR, REQ_ADDR, REQ_WDATA};
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fifo_cnt  <= '0;
         REQ_READY <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         fifo_cnt  <= fifo_cnt_nxt;
         REQ_READY <= (fifo_cnt_nxt != FULL_CNT);
      end
   end

   // ---------------- decode of the FIFO head ----------------
   logic       need_ext, req_bad;
   logic [7:0] cmd_byte;

   // Extended registers use the 0x2F escape in the TXCMD and send the
   // real address in a second byte.
   assign need_ext = EXT_ADDR_EN && (head_addr >= 8'h2F);
   assign cmd_byte = {1'b1, ~head_wr,
                      (head_addr < 8'h2F) ? head_addr[5:0] : 6'h2F};

   // Requests the build cannot serve are rejected without touching the bus.
   assign req_bad = (state == S_IDLE) && fifo_nempty &&
                    ((!READ_EN && !head_wr) ||
                     (!EXT_ADDR_EN && (head_addr >= 8'h2F)));

   // ---------------- completion / pop decisions ----------------
   logic stop_done, rd_capture, tmo_hit, rx_capture;

   assign stop_done  = (state == S_STOP);
   assign rd_capture = (state == S_RDATA) && ULPI_DIR && !ULPI_NXT;
   // A normal completion in the same cycle wins over the timeout.
   assign tmo_hit    = head_started && (tmo_cnt == TMO_LIMIT) &&
                       !stop_done && !rd_capture;
   assign pop        = req_bad | stop_done | rd_capture | tmo_hit;

   // RXCMD bytes arrive while the PHY owns the bus outside a read's data byte.
   assign rx_capture = ULPI_DIR && dir_q && !ULPI_NXT && (state != S_RDATA);

   // Drive only when the PHY neither holds nor is handing back the bus.
   assign ULPI_DATA_OE = ~ULPI_DIR & ~dir_q;
   assign BUSY         = fifo_nempty || (state != S_IDLE);

   // ---------------- transfer FSM ----------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= S_IDLE;
         dir_q         <= 1'b0;
         head_started  <= 1'b0;
         tmo_cnt       <= '0;
         ULPI_DATA_OUT <= 8'h00;
         ULPI_STP      <= 1'b1;
         RSP_VALID     <= 1'b0;
         RSP_ERR       <= 1'b0;
         RSP_RDATA     <= 8'h00;
         RXCMD_VALID   <= 1'b0;
         RXCMD         <= 8'h00;
         LINESTATE     <= 2'b00;
      end else begin
         dir_q       <= ULPI_DIR;
         ULPI_STP    <= 1'b0;
         RSP_VALID   <= 1'b0;
         RSP_ERR     <= 1'b0;
         RXCMD_VALID <= 1'b0;

         if (head_started) tmo_cnt <= tmo_cnt + 1'b1;
         if (pop)          head_started <= 1'b0;

         if (rx_capture) begin
            RXCMD       <= ULPI_DATA_IN;
            LINESTATE   <= ULPI_DATA_IN[1:0];
            RXCMD_VALID <= 1'b1;
         end

         if (tmo_hit) begin
            // Stop pulse only makes sense while the link owns the bus.
            ULPI_STP      <= ULPI_DATA_OE;
            ULPI_DATA_OUT <= 8'h00;
            RSP_VALID     <= 1'b1;
            RSP_ERR       <= 1'b1;
            state         <= S_WAIT_TA;
         end else begin
            case (state)
               S_IDLE: begin
                  if (req_bad) begin
                     RSP_VALID <= 1'b1;
                     RSP_ERR   <= 1'b1;
                  end else if (fifo_nempty && !ULPI_DIR && !dir_q) begin
                     state         <= S_CMD;
                     ULPI_DATA_OUT <= cmd_byte;
                     // Retries keep the running count of the first attempt.
                     if (!head_started) begin
                        head_started <= 1'b1;
                        tmo_cnt      <= '0;
                     end
                  end
               end
               S_CMD: begin
                  if (ULPI_DIR) begin
                     state         <= S_WAIT_TA;
                     ULPI_DATA_OUT <= 8'h00;
                  end else if (ULPI_NXT) begin
                     if (need_ext) begin
                        state         <= S_EXT;
                        ULPI_DATA_OUT <= head_addr;
                     end else if (head_wr) begin
                        state         <= S_WDATA;
                        ULPI_DATA_OUT <= head_wdata;
                     end else begin
                        state         <= S_RTURN;
                        ULPI_DATA_OUT <= 8'h00;
                     end
                  end
               end
               S_EXT: begin
                  if (ULPI_DIR) begin
                     state         <= S_WAIT_TA;
                     ULPI_DATA_OUT <= 8'h00;
                  end else if (ULPI_NXT) begin
                     if (head_wr) begin
                        state         <= S_WDATA;
                        ULPI_DATA_OUT <= head_wdata;
                     end else begin
                        state         <= S_RTURN;
                        ULPI_DATA_OUT <= 8'h00;
                     end
                  end
               end
               S_WDATA: begin
                  if (ULPI_DIR) begin
                     state         <= S_WAIT_TA;
                     ULPI_DATA_OUT <= 8'h00;
                  end else if (ULPI_NXT) begin
                     state         <= S_STOP;
                     ULPI_DATA_OUT <= 8'h00;
                     ULPI_STP      <= 1'b1;
                     RSP_VALID     <= 1'b1;
                  end
               end
               S_STOP: begin
                  state <= S_IDLE;
               end
               S_RTURN: begin
                  // The PHY must take the bus right after accepting a read.
                  state <= ULPI_DIR ? S_RDATA : S_WAIT_TA;
               end
               S_RDATA: begin
                  // NXT here means RxActive: the read is abandoned and retried.
                  if (rd_capture) begin
                     RSP_RDATA <= ULPI_DATA_IN;
                     RSP_VALID <= 1'b1;
                  end
                  state <= S_WAIT_TA;
               end
               S_WAIT_TA: begin
                  if (!ULPI_DIR && !dir_q) state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ulpi_reg_port.sv
// ---------------------------------------------------------------------------
// tb_ulpi_reg_port
//
// Directed bench for ulpi_reg_port. The main instance uses the default
// parameters. A second instance is built without extended addressing and
// without reads. Both instances share the same stimulus. Each scenario task
// drives the PHY side cycle by cycle and compares the outputs with values
// worked out by hand.
// ---------------------------------------------------------------------------
module tb_ulpi_reg_port;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_wr = 1'b0;
   logic [7:0] req_addr = 8'h00;
   logic [7:0] req_wdata = 8'h00;
   logic       dir = 1'b0;
   logic       nxt = 1'b0;
   logic [7:0] data_in = 8'h00;

   logic       req_ready, rsp_valid, rsp_err, busy, data_oe, stp, rxcmd_valid;
   logic [7:0] rsp_rdata, data_out, rxcmd;
   logic [1:0] linestate;

   logic       d2_req_ready, d2_rsp_valid, d2_rsp_err, d2_busy, d2_data_oe, d2_stp, d2_rxcmd_valid;
   logic [7:0] d2_rsp_rdata, d2_data_out, d2_rxcmd;
   logic [1:0] d2_linestate;

   int total = 0;
   int bad = 0;
   int rsp_seen = 0;

   ulpi_reg_port dut (
      .CLK(clk), .RST(rst),
      .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WR(req_wr),
      .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
      .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err), .BUSY(busy),
      .ULPI_DIR(dir), .ULPI_NXT(nxt), .ULPI_DATA_IN(data_in),
      .ULPI_DATA_OUT(data_out), .ULPI_DATA_OE(data_oe), .ULPI_STP(stp),
      .RXCMD_VALID(rxcmd_valid), .RXCMD(rxcmd), .LINESTATE(linestate)
   );

   ulpi_reg_port #(.EXT_ADDR_EN(1'b0), .READ_EN(1'b0)) dut2 (
      .CLK(clk), .RST(rst),
      .REQ_VALID(req_valid), .REQ_READY(d2_req_ready), .REQ_WR(req_wr),
      .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
      .RSP_VALID(d2_rsp_valid), .RSP_RDATA(d2_rsp_rdata), .RSP_ERR(d2_rsp_err), .BUSY(d2_busy),
      .ULPI_DIR(dir), .ULPI_NXT(nxt), .ULPI_DATA_IN(data_in),
      .ULPI_DATA_OUT(d2_data_out), .ULPI_DATA_OE(d2_data_oe), .ULPI_STP(d2_stp),
      .RXCMD_VALID(d2_rxcmd_valid), .RXCMD(d2_rxcmd), .LINESTATE(d2_linestate)
   );

   // ---------------- clock / watchdog / monitors ----------------
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1);
   end

   always @(negedge clk) begin
      if (rsp_valid === 1'b1) rsp_seen++;
   end

   // ---------------- driver tasks ----------------
   // One bus cycle: step to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = 1'b0; dir = 1'b0; nxt = 1'b0; data_in = 8'h00;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // Returns in the cycle right after the push edge.
   task automatic push_req(input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
      int n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      total++;
      if (req_ready !== 1'b1) begin bad++; $display("FAIL push_ready: req_ready=%b want 1", req_ready); end
      req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
      tick();
      req_valid = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++; if (stp !== 1'b1) begin bad++; $display("FAIL rst_stp: got %b want 1", stp); end
      total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", data_out); end
      total++;
      if ({req_ready, rsp_valid, rsp_err, busy, rxcmd_valid} !== 5'b00000) begin
         bad++; $display("FAIL rst_flags: got %b want 00000", {req_ready, rsp_valid, rsp_err, busy, rxcmd_valid});
      end
      total++;
      if ({rxcmd, linestate, rsp_rdata} !== 18'h0) begin
         bad++; $display("FAIL rst_regs: got %h want 0", {rxcmd, linestate, rsp_rdata});
      end
      rst = 1'b0;
      tick();
      total++; if (stp !== 1'b0) begin bad++; $display("FAIL rst_stp_release: got %b want 0", stp); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_release: got %b want 1", req_ready); end
   endtask

   task automatic test_rxcmd();
      dir = 1'b1;
      #1;
      total++; if (data_oe !== 1'b0) begin bad++; $display("FAIL rx_oe: got %b want 0", data_oe); end
      tick();
      data_in = 8'h4E;
      tick();
      total++;
      if ({rxcmd_valid, rxcmd, linestate} !== {1'b1, 8'h4E, 2'b10}) begin
         bad++; $display("FAIL rx_capture: got %b/%h/%b want 1/4e/10", rxcmd_valid, rxcmd, linestate);
      end
      dir = 1'b0;
      tick();
      total++; if (rxcmd_valid !== 1'b0) begin bad++; $display("FAIL rx_pulse: got %b want 0", rxcmd_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rx_busy: got %b want 0", busy); end
      data_in = 8'h00;
      tick();
   endtask

   task automatic test_write();
      push_req(1'b1, 8'h0A, 8'h45);
      tick();
      total++;
      if (data_out !== 8'h8A || data_oe !== 1'b1) begin
         bad++; $display("FAIL wr_txcmd: got %h oe=%b want 8a oe=1", data_out, data_oe);
      end
      tick();
      total++; if (data_out !== 8'h8A) begin bad++; $display("FAIL wr_txcmd_hold: got %h want 8a", data_out); end
      nxt = 1'b1;
      tick();
      total++; if (data_out !== 8'h45) begin bad++; $display("FAIL wr_data: got %h want 45", data_out); end
      tick();
      nxt = 1'b0;
      total++;
      if ({stp, data_out} !== {1'b1, 8'h00}) begin
         bad++; $display("FAIL wr_stop: got stp=%b data=%h want stp=1 data=00", stp, data_out);
      end
      total++;
      if ({rsp_valid, rsp_err} !== 2'b10) begin
         bad++; $display("FAIL wr_rsp: got %b want 10", {rsp_valid, rsp_err});
      end
      tick();
      total++;
      if ({stp, rsp_valid, busy} !== 3'b000) begin
         bad++; $display("FAIL wr_done: got %b want 000", {stp, rsp_valid, busy});
      end
   endtask

   task automatic test_ext_write();
      push_req(1'b1, 8'h3C, 8'h11);
      tick();
      total++; if (data_out !== 8'hAF) begin bad++; $display("FAIL ext_txcmd: got %h want af", data_out); end
      nxt = 1'b1;
      tick();
      total++; if (data_out !== 8'h3C) begin bad++; $display("FAIL ext_addr: got %h want 3c", data_out); end
      tick();
      total++; if (data_out !== 8'h11) begin bad++; $display("FAIL ext_data: got %h want 11", data_out); end
      tick();
      nxt = 1'b0;
      total++;
      if ({stp, rsp_valid, rsp_err, data_out} !== {3'b110, 8'h00}) begin
         bad++; $display("FAIL ext_stop: got %b/%h want 110/00", {stp, rsp_valid, rsp_err}, data_out);
      end
      total++; if (linestate !== 2'b10) begin bad++; $display("FAIL ext_linestate: got %b want 10", linestate); end
      tick();
   endtask

   task automatic test_read();
      push_req(1'b0, 8'h00, 8'h00);
      tick();
      total++; if (data_out !== 8'hC0) begin bad++; $display("FAIL rd_txcmd: got %h want c0", data_out); end
      nxt = 1'b1;
      tick();
      nxt = 1'b0;
      dir = 1'b1;
      #1;
      total++; if (data_oe !== 1'b0) begin bad++; $display("FAIL rd_turn_oe: got %b want 0", data_oe); end
      tick();
      data_in = 8'h24;
      tick();
      total++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'h24}) begin
         bad++; $display("FAIL rd_rsp: got %b/%h want 10/24", {rsp_valid, rsp_err}, rsp_rdata);
      end
      total++; if (rxcmd_valid !== 1'b0) begin bad++; $display("FAIL rd_no_rxcmd: got %b want 0", rxcmd_valid); end
      dir = 1'b0;
      data_in = 8'h00;
      tick();
      total++;
      if ({rsp_valid, rxcmd_valid, rsp_rdata} !== {2'b00, 8'h24}) begin
         bad++; $display("FAIL rd_hold: got %b/%h want 00/24", {rsp_valid, rxcmd_valid}, rsp_rdata);
      end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_idle: got busy=%b want 0", busy); end
   endtask

   task automatic test_abort();
      int base;
      logic found;
      base = rsp_seen;
      push_req(1'b1, 8'h04, 8'h77);
      tick();
      total++; if (data_out !== 8'h84) begin bad++; $display("FAIL ab_txcmd: got %h want 84", data_out); end
      dir = 1'b1;
      #1;
      total++; if (data_oe !== 1'b0) begin bad++; $display("FAIL ab_oe: got %b want 0", data_oe); end
      tick();
      data_in = 8'h54;
      total++;
      if ({rsp_valid, data_out} !== {1'b0, 8'h00}) begin
         bad++; $display("FAIL ab_quiet: got %b/%h want 0/00", rsp_valid, data_out);
      end
      tick();
      total++;
      if ({rxcmd_valid, rxcmd, linestate} !== {1'b1, 8'h54, 2'b00}) begin
         bad++; $display("FAIL ab_rxcmd: got %b/%h/%b want 1/54/00", rxcmd_valid, rxcmd, linestate);
      end
      dir = 1'b0;
      data_in = 8'h00;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (data_out === 8'h84 && data_oe === 1'b1) found = 1'b1;
      end
      total++; if (found !== 1'b1) begin bad++; $display("FAIL ab_reissue: got found=%b want 1", found); end
      nxt = 1'b1;
      tick();
      total++; if (data_out !== 8'h77) begin bad++; $display("FAIL ab_data: got %h want 77", data_out); end
      tick();
      nxt = 1'b0;
      total++;
      if ({stp, rsp_valid, rsp_err} !== 3'b110) begin
         bad++; $display("FAIL ab_stop: got %b want 110", {stp, rsp_valid, rsp_err});
      end
      tick();
      total++; if (rsp_seen - base !== 1) begin bad++; $display("FAIL ab_rsp_count: got %0d want 1", rsp_seen - base); end
   endtask

   task automatic test_timeout();
      int n = 0;
      push_req(1'b1, 8'h07, 8'h99);
      push_req(1'b1, 8'h08, 8'h66);
      // First CMD cycle: counter starts at 0 here and fires when it reads 1023.
      total++; if (data_out !== 8'h87) begin bad++; $display("FAIL to_txcmd: got %h want 87", data_out); end
      while (rsp_valid !== 1'b1 && n < 1100) begin
         tick();
         n++;
      end
      total++; if (n !== 1024) begin bad++; $display("FAIL to_latency: got %0d cycles want 1024", n); end
      total++;
      if ({stp, rsp_err, data_out} !== {2'b11, 8'h00}) begin
         bad++; $display("FAIL to_err: got %b/%h want 11/00", {stp, rsp_err}, data_out);
      end
      tick();
      total++; if ({stp, rsp_valid} !== 2'b00) begin bad++; $display("FAIL to_pulse: got %b want 00", {stp, rsp_valid}); end
      tick();
      total++; if (data_out !== 8'h88) begin bad++; $display("FAIL to_next_txcmd: got %h want 88", data_out); end
      nxt = 1'b1;
      tick();
      total++; if (data_out !== 8'h66) begin bad++; $display("FAIL to_next_data: got %h want 66", data_out); end
      tick();
      nxt = 1'b0;
      total++;
      if ({stp, rsp_valid, rsp_err} !== 3'b110) begin
         bad++; $display("FAIL to_next_rsp: got %b want 110", {stp, rsp_valid, rsp_err});
      end
      tick();
   endtask

   task automatic test_params();
      do_reset();
      push_req(1'b0, 8'h05, 8'h00);
      tick();
      total++;
      if ({d2_rsp_valid, d2_rsp_err, d2_stp, d2_busy} !== 4'b1100) begin
         bad++; $display("FAIL p_read_err: got %b want 1100", {d2_rsp_valid, d2_rsp_err, d2_stp, d2_busy});
      end
      total++; if (d2_data_out !== 8'h00) begin bad++; $display("FAIL p_read_bus: got %h want 00", d2_data_out); end
      push_req(1'b1, 8'h40, 8'h12);
      total++; if (d2_rsp_valid !== 1'b0) begin bad++; $display("FAIL p_ext_early: got %b want 0", d2_rsp_valid); end
      tick();
      total++;
      if ({d2_rsp_valid, d2_rsp_err, d2_stp, d2_busy} !== 4'b1100) begin
         bad++; $display("FAIL p_ext_err: got %b want 1100", {d2_rsp_valid, d2_rsp_err, d2_stp, d2_busy});
      end
      total++; if (d2_data_out !== 8'h00) begin bad++; $display("FAIL p_ext_bus: got %h want 00", d2_data_out); end
      do_reset();
   endtask

   task automatic test_full_and_reset();
      push_req(1'b1, 8'h01, 8'h11);
      push_req(1'b1, 8'h02, 8'h22);
      push_req(1'b1, 8'h03, 8'h33);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL full_3: got ready=%b want 1", req_ready); end
      push_req(1'b1, 8'h04, 8'h44);
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL full_4: got ready=%b want 0", req_ready); end
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h05; req_wdata = 8'h55;
      tick();
      req_valid = 1'b0;
      total++;
      if ({req_ready, busy} !== 2'b01) begin
         bad++; $display("FAIL full_5: got ready/busy=%b want 01", {req_ready, busy});
      end
      nxt = 1'b1;
      tick();
      nxt = 1'b0;
      total++; if (data_out !== 8'h11) begin bad++; $display("FAIL mid_wdata: got %h want 11", data_out); end
      rst = 1'b1;
      tick();
      total++;
      if ({stp, busy, req_ready, data_out} !== {3'b100, 8'h00}) begin
         bad++; $display("FAIL mid_rst: got %b/%h want 100/00", {stp, busy, req_ready}, data_out);
      end
      rst = 1'b0;
      tick();
      total++;
      if ({stp, busy, req_ready} !== 3'b001) begin
         bad++; $display("FAIL mid_release: got %b want 001", {stp, busy, req_ready});
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_rxcmd();
      test_write();
      test_ext_write();
      test_read();
      test_abort();
      test_timeout();
      test_params();
      test_full_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
